inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit, upstream of the single-cycle RV32 core. It takes the PC the core wants executed and runs a request/grant/response transaction on the instruction memory port. It then returns the 32-bit instruction word to the core's `cmd` input together with a one-cycle valid strobe. One transaction is outstanding at most; a kill input discards an in-flight fetch on redirect.

## Interface
- `ADDR_W`, 32: PC / memory address width.
- `RESET_PC`, 32'h8000_0000: value of `addr_o` and of the last-hit tag after reset.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_req_i`  in  1  core requests the instruction at `pc_i`; sampled only in IDLE.
- `pc_i`  in  ADDR_W  fetch address.
- `fetch_kill_i`  in  1  abandon the current fetch (branch redirect / flush).
- `cmd_o`  out  32  fetched instruction; holds its value until the next `cmd_valid_o`.
- `cmd_valid_o`  out  1  one-cycle strobe: `cmd_o` is new.
- `fault_o`  out  1  one-cycle strobe with `cmd_valid_o`: misaligned PC or bus error.
- `busy_o`  out  1  FSM not in IDLE.
- `mem_req_o`  out  1  memory request.
- `addr_o`  out  ADDR_W  memory address; stable while `mem_req_o` is high.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  response data valid.
- `mem_rdata_i`  in  32  response data.
- `mem_err_i`  in  1  bus error, qualified by `mem_rvalid_i`.

## Operation
FSM with four states: IDLE, REQ, WAIT and DROP.
- **IDLE**
  - If `fetch_req_i` is high and `fetch_kill_i` is low, latch `pc_i` into `addr_o`.
  - If `pc_i[1:0] != 0`: stay in IDLE, pulse `cmd_valid_o` and `fault_o` next cycle, set `cmd_o` to 32'h0000_0013 (NOP). No memory access is made.
  - Otherwise go to REQ.
- **REQ**
  - `mem_req_o` = 1.
  - On `mem_gnt_i`, go to WAIT.
  - On `fetch_kill_i` without grant, go to IDLE and drop `mem_req_o`. This is the only legal request withdrawal.
  - On `fetch_kill_i` with grant, go to DROP.
- **WAIT**
  - On `mem_rvalid_i`: register `mem_rdata_i` into `cmd_o`, pulse `cmd_valid_o`, set `fault_o` = `mem_err_i`, go to IDLE.
  - If `mem_err_i` is set, `cmd_o` is the NOP instead of the response data.
  - On `fetch_kill_i` (even in the same cycle as `rvalid`), go to DROP. If `rvalid` arrives in that same cycle, it is consumed and discarded, and the FSM returns to IDLE next cycle.
- **DROP**
  - Wait for `mem_rvalid_i`, discard the data (no strobe), go to IDLE.
- `fetch_kill_i` in IDLE is ignored. A request and a kill in the same IDLE cycle start nothing.
- `cmd_o` changes only at a strobe. `fault_o` is 0 whenever `cmd_valid_o` is 0.

## Timing
- Reset values:
  - state IDLE
  - `mem_req_o` = 0
  - `addr_o` = `RESET_PC`
  - `cmd_o` = 32'h0000_0013
  - `cmd_valid_o` = 0
  - `fault_o` = 0
  - `busy_o` = 0
- Reset mid-transaction returns to IDLE immediately. A later stray `mem_rvalid_i` in IDLE is ignored.
- Latency with grant in the first REQ cycle and `rvalid` N cycles after the grant (N ≥ 1):
  - `fetch_req_i` sampled in cycle 0.
  - `mem_req_o` high in cycle 1.
  - `cmd_valid_o` in cycle 2+N.
- Misaligned fault: strobe in cycle 1.
- `busy_o` is combinational from the state. All other outputs are registered.

## Configuration
- `IFU_LAST_HIT_EN` defined:
  - Add a valid bit, a tag (`ADDR_W`) and a data register, holding the last successful non-fault fetch.
  - In IDLE, an aligned `fetch_req_i` with `pc_i == tag` and valid set returns the stored word with a strobe in cycle 1, with no memory access.
  - Valid is cleared on reset and on any fault.
- Undefined: every aligned fetch goes to memory.

## Structure
- Shared package `ifu_pkg`:
  - state enum (IDLE, REQ, WAIT, DROP)
  - `NOP_INSN` = 32'h0000_0013
  - `IFU_ADDR_W` default
- Sub-module `ifu_hit_buf`: the tag/data/valid register, instantiated only under `IFU_LAST_HIT_EN`. Everything else is flat.

## Test plan
- **Zero-wait fetch:**
  - Stimulus: `fetch_req_i`=1, `pc_i`=0x8000_0000; memory grants immediately and returns 0x00500093 one cycle later.
  - Response: `mem_req_o` in cycle 1, `cmd_o`=0x00500093 with `cmd_valid_o` in cycle 3, `fault_o`=0.
- **Stalled grant:**
  - Stimulus: `mem_gnt_i` held low for 3 cycles.
  - Response: `addr_o` and `mem_req_o` stay stable throughout; strobe arrives 3 cycles later than in the zero-wait case.
- **Misaligned PC:**
  - Stimulus: `pc_i`=0x8000_0002.
  - Response: no `mem_req_o`; strobe in cycle 1 with `fault_o`=1 and `cmd_o`=0x00000013.
- **Kill in WAIT:**
  - Stimulus: kill asserted, then `rvalid` returns 0xDEADBEEF.
  - Response: no strobe, `cmd_o` unchanged, `busy_o` falls the cycle after `rvalid`; the next fetch completes normally.
- **Bus error:**
  - Stimulus: response with `mem_err_i`=1.
  - Response: `cmd_valid_o`=1, `fault_o`=1, `cmd_o`=NOP.
- **Last-hit (with `IFU_LAST_HIT_EN`):**
  - Stimulus: fetch 0x8000_0004 twice.
  - Response: the second fetch strobes in cycle 1 with no `mem_req_o`; after a fault, the same PC goes to memory again.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned IFU_ADDR_W = 32;
  localparam int unsigned INSN_W     = 32;

  // addi x0, x0, 0: returned on faults and held in cmd after reset
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } ifu_state_e;

  // RV32 instructions are word aligned; any low PC bit set is a fault
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Instruction memory request/grant/response port.
interface ifu_if
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W = IFU_ADDR_W
) ();

  logic              mem_req_o;
  logic [ADDR_W-1:0] addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [INSN_W-1:0] mem_rdata_i;
  logic              mem_err_i;

  // fetch unit side
  modport master (
    output mem_req_o,
    output addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i,
    input  mem_err_i
  );

  // memory side
  modport slave (
    input  mem_req_o,
    input  addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i,
    output mem_err_i
  );

endinterface

// File: rtl/ifu_hit_buf.sv
// Single-entry buffer holding the last successful, non-faulting fetch.
module ifu_hit_buf
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_TAG = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] tag_i,
  input  logic [INSN_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_c_o,
  output logic [INSN_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [INSN_W-1:0] data_q;

  // Entry update: clear wins over write so a fault always invalidates
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= RESET_TAG;
      data_q  <= NOP_INSN;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      tag_q   <= tag_i;
      data_q  <= data_i;
    end
  end

  assign hit_c_o = valid_q && (pc_i == tag_q);
  assign data_o  = data_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding request/grant/response fetch
// with kill support. Optional last-hit buffer under IFU_LAST_HIT_EN.
module inst_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              fetch_kill_i,
  output logic [INSN_W-1:0] cmd_o,
  output logic              cmd_valid_o,
  output logic              fault_o,
  output logic              busy_o,
  ifu_if.master             mem
);

  ifu_state_e        state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INSN_W-1:0] cmd_q;
  logic              cmd_valid_q;
  logic              fault_q;

  logic              start_c;
  logic              misalign_c;
  logic              hit_c;
  logic [INSN_W-1:0] hit_data;

  assign start_c    = (state_q == ST_IDLE) && fetch_req_i && !fetch_kill_i;
  assign misalign_c = pc_misaligned(pc_i[1:0]);

`ifdef IFU_LAST_HIT_EN
  logic hb_clr_c;
  logic hb_wr_c;
  logic rsp_ok_c;

  // Buffer maintenance: refill on a clean response, invalidate on any fault
  assign rsp_ok_c = (state_q == ST_WAIT) && mem.mem_rvalid_i && !fetch_kill_i;
  assign hb_wr_c  = rsp_ok_c && !mem.mem_err_i;
  assign hb_clr_c = (start_c && misalign_c) || (rsp_ok_c && mem.mem_err_i);

  ifu_hit_buf #(
    .ADDR_W    (ADDR_W),
    .RESET_TAG (RESET_PC)
  ) u_hit_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (hb_clr_c),
    .wr_i    (hb_wr_c),
    .tag_i   (addr_q),
    .data_i  (mem.mem_rdata_i),
    .pc_i    (pc_i),
    .hit_c_o (hit_c),
    .data_o  (hit_data)
  );
`else
  assign hit_c    = 1'b0;
  assign hit_data = NOP_INSN;
`endif

  // Fetch FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      addr_q      <= RESET_PC;
      cmd_q       <= NOP_INSN;
      cmd_valid_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            addr_q <= pc_i;
            if (misalign_c) begin
              cmd_q       <= NOP_INSN;
              cmd_valid_q <= 1'b1;
              fault_q     <= 1'b1;
            end else if (hit_c) begin
              cmd_q       <= hit_data;
              cmd_valid_q <= 1'b1;
            end else begin
              state_q   <= ST_REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          // a kill without grant is the only legal request withdrawal
          if (mem.mem_gnt_i) begin
            mem_req_q <= 1'b0;
            state_q   <= fetch_kill_i ? ST_DROP : ST_WAIT;
          end else if (fetch_kill_i) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (fetch_kill_i) begin
            // a response arriving with the kill is consumed here
            state_q <= mem.mem_rvalid_i ? ST_IDLE : ST_DROP;
          end else if (mem.mem_rvalid_i) begin
            cmd_q       <= mem.mem_err_i ? NOP_INSN : mem.mem_rdata_i;
            cmd_valid_q <= 1'b1;
            fault_q     <= mem.mem_err_i;
            state_q     <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (mem.mem_rvalid_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign cmd_o         = cmd_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign fault_o       = fault_q;
  assign mem.mem_req_o = mem_req_q;
  assign mem.addr_o    = addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; last-hit checks adapt to IFU_LAST_HIT_EN.
module tb_inst_fetch;
  import ifu_pkg::*;

  logic        clk;
  logic        rst;
  logic        fetch_req_i;
  logic [31:0] pc_i;
  logic        fetch_kill_i;
  logic [31:0] cmd_o;
  logic        cmd_valid_o;
  logic        fault_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_if mem_bus ();

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_req_i  (fetch_req_i),
    .pc_i         (pc_i),
    .fetch_kill_i (fetch_kill_i),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .fault_o      (fault_o),
    .busy_o       (busy_o),
    .mem          (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch from IDLE with a scripted memory; returns strobe cycle
  // (cycle 0 = request cycle, -1 if no strobe within the budget).
  task automatic fetch(input logic [31:0] pc, input int gnt_dly,
                       input logic [31:0] data, input logic err,
                       output int lat, output logic [31:0] cmd, output logic flt,
                       output int req_cycles, output logic addr_ok);
    lat = -1; cmd = '0; flt = 1'b0; req_cycles = 0; addr_ok = 1'b1;
    fetch_req_i = 1'b1;
    pc_i        = pc;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      fetch_req_i            = 1'b0;
      mem_bus.mem_gnt_i      = (c == 1 + gnt_dly);
      mem_bus.mem_rvalid_i   = (c == 2 + gnt_dly);
      mem_bus.mem_rdata_i    = data;
      mem_bus.mem_err_i      = err;
      if (mem_bus.mem_req_o) begin
        req_cycles++;
        if (mem_bus.addr_o !== pc) addr_ok = 1'b0;
      end
      if (cmd_valid_o) begin
        lat = c;
        cmd = cmd_o;
        flt = fault_o;
      end
    end
    mem_bus.mem_gnt_i    = 1'b0;
    mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_err_i    = 1'b0;
  endtask

  int          lat;
  int          nreq;
  logic [31:0] cmd;
  logic        flt;
  logic        aok;

  initial begin
    rst = 1'b1; fetch_req_i = 1'b0; fetch_kill_i = 1'b0; pc_i = '0;
    mem_bus.mem_gnt_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_rdata_i = '0; mem_bus.mem_err_i = 1'b0;
    tick(); tick();
    check("rst_cmd",   cmd_o, 32'h0000_0013);
    check("rst_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_fault", 32'(fault_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);
    check("rst_req",   32'(mem_bus.mem_req_o), 32'd0);
    check("rst_addr",  mem_bus.addr_o, 32'h8000_0000);
    rst = 1'b0;
    tick();

    // zero-wait fetch
    fetch(32'h8000_0000, 0, 32'h0050_0093, 1'b0, lat, cmd, flt, nreq, aok);
    check("zw_lat",  32'(lat), 32'd3);
    check("zw_cmd",  cmd, 32'h0050_0093);
    check("zw_flt",  32'(flt), 32'd0);
    check("zw_req",  32'(nreq), 32'd1);
    check("zw_addr", 32'(aok), 32'd1);

    // stalled grant: request held 4 cycles, strobe 3 cycles later
    fetch(32'h8000_0008, 3, 32'h00A0_0113, 1'b0, lat, cmd, flt, nreq, aok);
    check("st_lat",  32'(lat), 32'd6);
    check("st_cmd",  cmd, 32'h00A0_0113);
    check("st_req",  32'(nreq), 32'd4);
    check("st_addr", 32'(aok), 32'd1);

    // misaligned PC
    fetch(32'h8000_0002, 0, 32'h1234_5678, 1'b0, lat, cmd, flt, nreq, aok);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_cmd", cmd, 32'h0000_0013);
    check("mis_flt", 32'(flt), 32'd1);
    check("mis_req", 32'(nreq), 32'd0);
    tick();
    check("mis_valid_drop", 32'(cmd_valid_o), 32'd0);
    check("mis_fault_drop", 32'(fault_o), 32'd0);

    fetch(32'h8000_0024, 0, 32'h0000_0297, 1'b0, lat, cmd, flt, nreq, aok);
    check("n2_cmd", cmd, 32'h0000_0297);

    // kill in WAIT, response later in DROP
    fetch_req_i = 1'b1; pc_i = 32'h8000_000C;
    tick(); fetch_req_i = 1'b0; mem_bus.mem_gnt_i = 1'b1;
    check("kw_req", 32'(mem_bus.mem_req_o), 32'd1);
    tick(); mem_bus.mem_gnt_i = 1'b0; fetch_kill_i = 1'b1;
    tick(); fetch_kill_i = 1'b0;
    check("kw_busy_drop", 32'(busy_o), 32'd1);
    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'hDEAD_BEEF;
    tick(); mem_bus.mem_rvalid_i = 1'b0;
    check("kw_valid", 32'(cmd_valid_o), 32'd0);
    check("kw_busy",  32'(busy_o), 32'd0);
    check("kw_cmd",   cmd_o, 32'h0000_0297);
    fetch(32'h8000_0010, 0, 32'h0020_A023, 1'b0, lat, cmd, flt, nreq, aok);
    check("kw_next_lat", 32'(lat), 32'd3);
    check("kw_next_cmd", cmd, 32'h0020_A023);

    // kill and rvalid in the same WAIT cycle
    fetch_req_i = 1'b1; pc_i = 32'h8000_0018;
    tick(); fetch_req_i = 1'b0; mem_bus.mem_gnt_i = 1'b1;
    tick(); mem_bus.mem_gnt_i = 1'b0; fetch_kill_i = 1'b1;
    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'hCAFE_F00D;
    tick(); fetch_kill_i = 1'b0; mem_bus.mem_rvalid_i = 1'b0;
    check("kr_busy",  32'(busy_o), 32'd0);
    check("kr_valid", 32'(cmd_valid_o), 32'd0);
    check("kr_cmd",   cmd_o, 32'h0020_A023);

    // kill in REQ without grant withdraws the request
    fetch_req_i = 1'b1; pc_i = 32'h8000_001C;
    tick(); fetch_req_i = 1'b0;
    check("kq_req_on", 32'(mem_bus.mem_req_o), 32'd1);
    fetch_kill_i = 1'b1;
    tick(); fetch_kill_i = 1'b0;
    check("kq_req_off", 32'(mem_bus.mem_req_o), 32'd0);
    check("kq_busy",    32'(busy_o), 32'd0);

    // request with kill in IDLE starts nothing
    fetch_req_i = 1'b1; fetch_kill_i = 1'b1; pc_i = 32'h8000_0020;
    tick(); fetch_req_i = 1'b0; fetch_kill_i = 1'b0;
    check("ki_busy", 32'(busy_o), 32'd0);
    check("ki_req",  32'(mem_bus.mem_req_o), 32'd0);
    check("ki_addr", mem_bus.addr_o, 32'h8000_001C);

    // bus error
    fetch(32'h8000_0014, 0, 32'h1234_5678, 1'b1, lat, cmd, flt, nreq, aok);
    check("be_lat", 32'(lat), 32'd3);
    check("be_cmd", cmd, 32'h0000_0013);
    check("be_flt", 32'(flt), 32'd1);

    // reset mid-transaction, then a stray response
    fetch_req_i = 1'b1; pc_i = 32'h8000_0028;
    tick(); fetch_req_i = 1'b0; mem_bus.mem_gnt_i = 1'b1;
    tick(); mem_bus.mem_gnt_i = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    check("rm_busy", 32'(busy_o), 32'd0);
    check("rm_addr", mem_bus.addr_o, 32'h8000_0000);
    mem_bus.mem_rvalid_i = 1'b1; mem_bus.mem_rdata_i = 32'h1111_1111;
    tick(); mem_bus.mem_rvalid_i = 1'b0;
    check("rm_valid", 32'(cmd_valid_o), 32'd0);
    check("rm_busy2", 32'(busy_o), 32'd0);
    check("rm_cmd",   cmd_o, 32'h0000_0013);

    // last-hit: repeat fetch, then fault invalidates
    fetch(32'h8000_0004, 0, 32'h0040_0193, 1'b0, lat, cmd, flt, nreq, aok);
    check("lh_first_lat", 32'(lat), 32'd3);
    fetch(32'h8000_0004, 0, 32'h0BAD_0BAD, 1'b0, lat, cmd, flt, nreq, aok);
`ifdef IFU_LAST_HIT_EN
    check("lh_hit_lat", 32'(lat), 32'd1);
    check("lh_hit_req", 32'(nreq), 32'd0);
    check("lh_hit_cmd", cmd, 32'h0040_0193);
    check("lh_hit_flt", 32'(flt), 32'd0);
`else
    check("lh_miss_lat", 32'(lat), 32'd3);
    check("lh_miss_req", 32'(nreq), 32'd1);
    check("lh_miss_cmd", cmd, 32'h0BAD_0BAD);
`endif
    fetch(32'h8000_0006, 0, 32'h0, 1'b0, lat, cmd, flt, nreq, aok);
    check("lh_fault_flt", 32'(flt), 32'd1);
    fetch(32'h8000_0004, 0, 32'h0040_0213, 1'b0, lat, cmd, flt, nreq, aok);
    check("lh_after_lat", 32'(lat), 32'd3);
    check("lh_after_req", 32'(nreq), 32'd1);
    check("lh_after_cmd", cmd, 32'h0040_0213);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
